// File: rtl/multiplexer_4to1_structural.sv
// multiplexer_4to1_structural: gate-level 4:1 mux (decode + AND-OR) with an enabled output register
module multiplexer_4to1_structural #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    input  logic             en,
    output logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] cout_q,
    output logic [3:0]       sel_oh
);
    logic             s1_n, s2_n;
    logic [WIDTH-1:0] ta, tb, tc, td, oab, ocd;

    not (s1_n, s1);
    not (s2_n, s2);
    and (sel_oh[0], s1_n, s2_n);
    and (sel_oh[1], s1_n, s2);
    and (sel_oh[2], s1, s2_n);
    and (sel_oh[3], s1, s2);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and (ta[i], a[i], sel_oh[0]);
        and (tb[i], b[i], sel_oh[1]);
        and (tc[i], c[i], sel_oh[2]);
        and (td[i], d[i], sel_oh[3]);
        or  (oab[i], ta[i], tb[i]);
        or  (ocd[i], tc[i], td[i]);
        or  (cout[i], oab[i], ocd[i]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cout_q <= RESET_VAL;
        else if (en) cout_q <= cout;
endmodule

// File: tb/tb_multiplexer_4to1_structural.sv
// tb_multiplexer_4to1_structural: directed table, register-path sequences and an 8-bit random sweep
module tb_multiplexer_4to1_structural;
    logic       clk = 0, rst_n = 1, en = 0;
    logic       s1 = 0, s2 = 0, t1 = 0, t2 = 0;
    logic       a = 0, b = 0, c = 0, d = 0;
    logic       cout, cout_q;
    logic [3:0] oh, oh8;
    logic [7:0] a8 = 0, b8 = 0, c8 = 0, d8 = 0, cout8, q8;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    multiplexer_4to1_structural #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
        .en(en), .cout(cout), .cout_q(cout_q), .sel_oh(oh));

    multiplexer_4to1_structural #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .d(d8), .s1(t1), .s2(t2),
        .en(en), .cout(cout8), .cout_q(q8), .sel_oh(oh8));

    typedef struct {
        logic s1, s2, a, b, c, d, y;
        logic [3:0] oh;
    } vec_t;
    vec_t tv[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic       e1;
        logic [7:0] exp_q, y;
        logic [1:0] sv;
        logic       dv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        // s1 s2 a b c d -> cout sel_oh
        tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0001};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001};
        tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000};
        tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010};
        tv[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100};

        #2 rst_n = 0;
        #1;
        chk("rst_cout", cout, 0);
        chk("rst_cout_q", cout_q, 0);
        chk("rst_q8", q8, 8'hA5);
        chk("rst_sel_oh", oh, 4'b0001);
        @(posedge clk); #1;
        chk("rst_hold_across_edge", cout_q, 0);

        rst_n = 1;
        a = 1;
        #1 chk("release_no_load", cout_q, 0);
        @(posedge clk); #1;
        chk("release_en0_hold", cout_q, 0);
        en = 1;
        #1 chk("release_before_first_edge", cout_q, 0);
        @(posedge clk); #1;
        chk("first_enabled_load", cout_q, 1);
        e1 = 1;
        en = 0;

        for (int i = 0; i < 13; i++) begin
            {s1, s2, a, b, c, d} = {tv[i].s1, tv[i].s2, tv[i].a, tv[i].b, tv[i].c, tv[i].d};
            #1;
            chk($sformatf("vec%0d_cout", i), cout, tv[i].y);
            chk($sformatf("vec%0d_sel_oh", i), oh, tv[i].oh);
        end

        @(posedge clk); #1;
        {s1, s2, a, b, c} = 5'b11000;
        en = 1;
        for (int i = 0; i < 4; i++) begin
            d = dv[i];
            #1;
            chk($sformatf("reg%0d_cout", i), cout, dv[i]);
            chk($sformatf("reg%0d_q_pre_edge", i), cout_q, e1);
            @(posedge clk); #1;
            e1 = dv[i];
            chk($sformatf("reg%0d_q_post_edge", i), cout_q, e1);
        end

        en = 0;
        for (int i = 0; i < 3; i++) begin
            d = dv[i];
            #1 chk($sformatf("frz%0d_cout", i), cout, dv[i]);
            @(posedge clk); #1;
            chk($sformatf("frz%0d_q", i), cout_q, e1);
        end

        d = 1;
        #2 rst_n = 0;
        #1;
        chk("midrst_q", cout_q, 0);
        chk("midrst_q8", q8, 8'hA5);
        chk("midrst_cout_live", cout, 1);
        en = 1;
        @(posedge clk); #1;
        chk("midrst_hold_en1", cout_q, 0);
        en = 0;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_q", cout_q, 0);
        chk("post_rst_q8", q8, 8'hA5);

        exp_q = 8'hA5;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 8'($urandom);
            d8 = 8'($urandom);
            sv = 2'($urandom);
            {t1, t2} = sv;
            en = ($urandom_range(0, 3) != 0);
            #1;
            y = sv == 2'd0 ? a8 : sv == 2'd1 ? b8 : sv == 2'd2 ? c8 : d8;
            chk($sformatf("rnd%0d_cout8", i), cout8, y);
            chk($sformatf("rnd%0d_sel_oh8", i), oh8, 4'b0001 << sv);
            @(posedge clk);
            if (en) exp_q = y;
            #1 chk($sformatf("rnd%0d_q8", i), q8, exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplexer_4to1_structural.md
Name: multiplexer_4to1_structural

Overview:
- Four-input, one-output selector built as a gate-level decode + AND-OR network. The data inputs are a, b, c and d, and the two select lines are s1 and s2.
- Provides a combinational output cout, plus a registered copy cout_q for downstream synchronous logic.
- Used as a leaf datapath primitive in small control/datapath blocks. It is also a reference structural cell for the behavioural mux variant.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs; legal range 1..64.
- RESET_VAL, 0, value loaded into cout_q while reset is asserted (WIDTH bits, zero-extended).

Ports:
- clk  input  1  rising-edge clock for the output register only.
- rst_n  input  1  asynchronous, active-low reset of the output register.
- a  input  WIDTH  data input 0.
- b  input  WIDTH  data input 1.
- c  input  WIDTH  data input 2.
- d  input  WIDTH  data input 3.
- s1  input  1  select MSB.
- s2  input  1  select LSB.
- en  input  1  load enable for cout_q.
- cout  output  WIDTH  combinational selected data.
- cout_q  output  WIDTH  registered selected data.
- sel_oh  output  4  one-hot decode of the select lines, bit0=a … bit3=d.

Behaviour:
- Select index = {s1,s2}:
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- Decode stage:
  - sel_oh[0] = ~s1&~s2
  - sel_oh[1] = ~s1&s2
  - sel_oh[2] = s1&~s2
  - sel_oh[3] = s1&s2
  - Exactly one bit is high for known selects.
- Datapath, per bit i: cout[i] = (a[i]&sel_oh[0]) | (b[i]&sel_oh[1]) | (c[i]&sel_oh[2]) | (d[i]&sel_oh[3]).
  - Build it from explicit 2-input AND/OR and NOT gate instances, not conditional operators.
- cout and sel_oh are purely combinational:
  - Zero-cycle latency; no dependence on clk, rst_n or en.
  - Valid during reset.
- Changes on unselected inputs have no effect on cout, on any bit or in any combination.
- cout_q behaviour:
  - rst_n low: cout_q = RESET_VAL immediately (asynchronous), independent of clk.
  - rst_n high, rising clk, en=1: cout_q <= cout, giving 1-cycle latency.
  - en=0: cout_q holds its value.
- Reset release coincident with a clk edge: the first load occurs on the next rising edge after rst_n is sampled high. No load may occur on the release edge itself.
- Select and data changing simultaneously: cout reflects the new select applied to the new data after gate settling. cout_q captures whatever cout is at the clock edge.
- X/Z on s1 or s2: sel_oh and cout may go X. cout_q is not defined for this case in simulation.
- No internal state other than the cout_q register.

Test Plan:
- Reset: rst_n=0, all inputs 0 -> cout=0, cout_q=RESET_VAL(0), sel_oh=0001. Release rst_n; cout_q stays 0 until the first enabled edge.
- Select 00, step data:
  - a=1,c=1 -> cout=1.
  - Then d=1,b=1 -> cout=1.
  - Then a=0,c=0 -> cout=0.
  - Proves only a propagates.
- Select 11, step data from a=b=c=d=... per stage:
  - a=1,c=1 with d=1 -> cout=1.
  - d=0,b=0 -> cout=0.
  - a=0,c=0 -> cout=0.
  - d=1,b=1 -> cout=1.
  - Proves only d propagates.
- Selects 01 and 10, one-hot data (b only, then c only), WIDTH=1 -> cout=1 only when the matching input is 1. sel_oh=0010 and 0100 respectively.
- Register path, en=1 with select 11 and d toggling 0,1,0 each cycle -> cout_q follows cout delayed by exactly one clk.
  - Set en=0 -> cout_q frozen while cout keeps changing.
  - Assert rst_n=0 mid-cycle -> cout_q=0 before the next edge.
- WIDTH=8 random sweep: 1000 random a..d and selects -> cout equals the selected input every vector. cout_q equals the previous cycle's cout when en=1.
